// File: rtl/trivium_ks_xor_pkg.sv
// Constants shared between the Trivium keystream core and its XOR stage.
// BLK_W  : keystream block width, equal to the core's OUT width
// WORD_W : plaintext/ciphertext word width
// NWORDS : words per keystream block
// IDX_W  : width of a word index within a block
package trivium_ks_xor_pkg;

   localparam int unsigned BLK_W  = 512;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned NWORDS = BLK_W / WORD_W;
   localparam int unsigned IDX_W  = $clog2(NWORDS);

   // Block buffer occupancy; LOADED means blk holds unused keystream words.
   typedef enum logic {
      EMPTY  = 1'b0,
      LOADED = 1'b1
   } blk_state_e;

endpackage

// File: rtl/trivium_ks_xor.sv
// Keystream XOR stage: buffers one keystream block from the core and XORs it
// word by word (word 0 first) with the plaintext stream to form ciphertext.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   ks_in/valid/ready  : keystream block handshake (ks_in fed from core OUT)
//   pt_data/valid/last : plaintext word stream, pt_ready = accepted this cycle
//   ct_data/valid/last : registered ciphertext word stream, ct_ready from sink
//   word_cnt           : ciphertext words emitted since reset, wraps silently
module trivium_ks_xor
   import trivium_ks_xor_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BLK_W-1:0]  ks_in,
   input  logic              ks_valid,
   output logic              ks_ready,
   input  logic [WORD_W-1:0] pt_data,
   input  logic              pt_valid,
   input  logic              pt_last,
   output logic              pt_ready,
   output logic [WORD_W-1:0] ct_data,
   output logic              ct_valid,
   output logic              ct_last,
   input  logic              ct_ready,
   output logic [CNT_W-1:0]  word_cnt
);

   blk_state_e        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [BLK_W-1:0]  blk_q;
   logic [WORD_W-1:0] ks_word;
   logic [WORD_W-1:0] ct_data_d;
   logic              ct_valid_d, ct_last_d;
   logic [CNT_W-1:0]  cnt_d;
   logic              blk_valid, out_free, pt_fire, blk_release, ks_fire;

   // Handshake qualifiers; the block is released on its last word or on pt_last
   // so that a new message always starts on a fresh block.
   assign blk_valid   = (state_q == LOADED);
   assign out_free    = !ct_valid || ct_ready;
   assign pt_ready    = blk_valid && out_free;
   assign pt_fire     = pt_valid && pt_ready;
   assign blk_release = pt_fire && ((idx_q == IDX_W'(NWORDS - 1)) || pt_last);
   assign ks_ready    = !blk_valid || blk_release;
   assign ks_fire     = ks_valid && ks_ready;

   assign ks_word = blk_q[WORD_W*idx_q +: WORD_W];

   // Next-state and output-register logic.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      ct_data_d  = ct_data;
      ct_valid_d = ct_valid;
      ct_last_d  = ct_last;
      cnt_d      = word_cnt;

      if (pt_fire) begin
         ct_data_d  = pt_data ^ ks_word;
         ct_valid_d = 1'b1;
         ct_last_d  = pt_last;
         idx_d      = IDX_W'(idx_q + 1'b1);
         cnt_d      = CNT_W'(word_cnt + 1'b1);
      end else if (ct_ready) begin
         ct_valid_d = 1'b0;
         ct_last_d  = 1'b0;
      end

      // A load in the release cycle swaps blocks with no bubble.
      if (ks_fire) begin
         state_d = LOADED;
         idx_d   = '0;
      end else if (blk_release) begin
         state_d = EMPTY;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= EMPTY;
         idx_q    <= '0;
         ct_data  <= '0;
         ct_valid <= 1'b0;
         ct_last  <= 1'b0;
         word_cnt <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         ct_data  <= ct_data_d;
         ct_valid <= ct_valid_d;
         ct_last  <= ct_last_d;
         word_cnt <= cnt_d;
      end
   end

   // Keystream buffer; contents are only meaningful while LOADED.
   always_ff @(posedge clk) begin
      if (ks_fire) blk_q <= ks_in;
   end

endmodule

// File: tb/tb_trivium_ks_xor.sv
module tb_trivium_ks_xor;
   import trivium_ks_xor_pkg::*;

   localparam int unsigned TB_CNT_W = 6;
   localparam int          TMO      = 2000;

   logic                clk = 1'b0;
   logic                reset;
   logic [BLK_W-1:0]    ks_in;
   logic                ks_valid, ks_ready;
   logic [WORD_W-1:0]   pt_data;
   logic                pt_valid, pt_last, pt_ready;
   logic [WORD_W-1:0]   ct_data;
   logic                ct_valid, ct_last, ct_ready;
   logic [TB_CNT_W-1:0] word_cnt;

   trivium_ks_xor #(.CNT_W(TB_CNT_W)) dut (
      .clk(clk), .reset(reset),
      .ks_in(ks_in), .ks_valid(ks_valid), .ks_ready(ks_ready),
      .pt_data(pt_data), .pt_valid(pt_valid), .pt_last(pt_last), .pt_ready(pt_ready),
      .ct_data(ct_data), .ct_valid(ct_valid), .ct_last(ct_last), .ct_ready(ct_ready),
      .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      logic [WORD_W-1:0] d;
      logic              l;
      int                fc;
   } exp_t;

   exp_t             exp_q[$];
   logic [BLK_W-1:0] mblk[$];   // keystream blocks in the order the core offered them
   int               mk = 0;    // next unused word of mblk[0]
   bit               chk_lat = 1'b0;
   bit               rnd_bp  = 1'b0;
   int               last_fc = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, got, want);
      end
   endtask

   function automatic logic [BLK_W-1:0] fill_blk(input logic [WORD_W-1:0] w);
      logic [BLK_W-1:0] b;
      for (int k = 0; k < int'(NWORDS); k++) b[WORD_W*k +: WORD_W] = w;
      return b;
   endfunction

   function automatic logic [BLK_W-1:0] rand_blk();
      logic [BLK_W-1:0] b;
      for (int k = 0; k < int'(NWORDS); k++) b[WORD_W*k +: WORD_W] = $urandom;
      return b;
   endfunction

   task automatic do_reset();
      reset    = 1'b1;
      ks_valid = 1'b0;
      pt_valid = 1'b0;
      pt_last  = 1'b0;
      exp_q.delete();
      mblk.delete();
      mk = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      chk({tag, "_ct_valid"}, 64'(ct_valid), 64'(0));
      chk({tag, "_ct_last"},  64'(ct_last),  64'(0));
      chk({tag, "_ct_data"},  64'(ct_data),  64'(0));
      chk({tag, "_word_cnt"}, 64'(word_cnt), 64'(0));
      chk({tag, "_ks_ready"}, 64'(ks_ready), 64'(1));
      chk({tag, "_pt_ready"}, 64'(pt_ready), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic send_block(input logic [BLK_W-1:0] b, input int gap);
      int n = 0;
      repeat (gap) begin @(posedge clk); #1; end
      ks_in    = b;
      ks_valid = 1'b1;
      @(negedge clk);
      while (!ks_ready && n < TMO) begin @(negedge clk); n++; end
      if (!ks_ready) begin
         total++; bad++;
         $display("FAIL ks_accept_timeout: got ks_ready=0 want 1 within %0d cycles", TMO);
         ks_valid = 1'b0;
         return;
      end
      mblk.push_back(b);
      @(posedge clk);
      #1 ks_valid = 1'b0;
   endtask

   task automatic send_word(input logic [WORD_W-1:0] d, input logic last, input int gap);
      int n = 0;
      exp_t e;
      logic [BLK_W-1:0] b;
      repeat (gap) begin @(posedge clk); #1; end
      pt_data  = d;
      pt_last  = last;
      pt_valid = 1'b1;
      @(negedge clk);
      while (!pt_ready && n < TMO) begin @(negedge clk); n++; end
      if (!pt_ready) begin
         total++; bad++;
         $display("FAIL pt_accept_timeout: got pt_ready=0 want 1 within %0d cycles", TMO);
         pt_valid = 1'b0;
         pt_last  = 1'b0;
         return;
      end
      if (mblk.size() == 0) begin
         total++; bad++;
         $display("FAIL pt_no_block: got pt_ready=1 want 0 (no keystream block offered)");
      end else begin
         b    = mblk[0];
         e.d  = d ^ b[WORD_W*mk +: WORD_W];
         e.l  = last;
         e.fc = cyc + 1;
         exp_q.push_back(e);
         mk++;
         if (mk == int'(NWORDS) || last) begin
            void'(mblk.pop_front());
            mk = 0;
         end
      end
      last_fc = cyc + 1;
      @(posedge clk);
      #1;
      pt_valid = 1'b0;
      pt_last  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < TMO) begin @(posedge clk); n++; end
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: got %0d words pending want 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Random sink backpressure.
   always @(posedge clk) begin
      if (rnd_bp) begin
         #1 ct_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops the scoreboard on each ciphertext transfer and checks stall behaviour.
   exp_t              mon_e;
   logic              prev_ok = 1'b0, prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
   logic [WORD_W-1:0] prev_d = '0;
   always @(negedge clk) begin
      if (!reset) begin
         if (prev_ok && prev_v && !prev_r) begin
            chk("hold_ct_data",  64'(ct_data),  64'(prev_d));
            chk("hold_ct_last",  64'(ct_last),  64'(prev_l));
            chk("hold_ct_valid", 64'(ct_valid), 64'(1));
         end
         if (ct_valid && !ct_ready) chk("pt_ready_stall", 64'(pt_ready), 64'(0));
         if (ct_valid && ct_ready) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL ct_unexpected: got ct_data=%0h want no word", ct_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("ct_data", 64'(ct_data), 64'(mon_e.d));
               chk("ct_last", 64'(ct_last), 64'(mon_e.l));
               if (chk_lat) chk("ct_latency_cycle", 64'(cyc), 64'(mon_e.fc));
            end
         end
      end
      prev_ok = !reset;
      prev_v  = ct_valid;
      prev_r  = ct_ready;
      prev_d  = ct_data;
      prev_l  = ct_last;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish within 500000 time units");
      $fatal(1);
   end

   initial begin
      logic [BLK_W-1:0] ramp;
      int first_fc;
      int lens[12];
      int nblk;

      ks_in    = '0;
      pt_data  = '0;
      ct_ready = 1'b1;
      do_reset();
      check_idle("reset");

      // Word ordering: word k = 0x01010101*k, plaintext all ones.
      for (int k = 0; k < int'(NWORDS); k++) ramp[WORD_W*k +: WORD_W] = WORD_W'(32'h0101_0101 * k);
      chk_lat = 1'b1;
      fork
         send_block(ramp, 0);
         for (int i = 0; i < int'(NWORDS); i++) send_word('1, 1'b0, 0);
      join
      drain();
      @(negedge clk);
      chk("order_ks_ready", 64'(ks_ready), 64'(1));
      chk("order_word_cnt", 64'(word_cnt), 64'(16));
      @(posedge clk); #1;

      // Back-to-back blocks with no bubble.
      do_reset();
      fork
         begin
            send_block(fill_blk(32'hA5A5_A5A5), 0);
            send_block(fill_blk(32'h5A5A_5A5A), 0);
         end
         for (int i = 0; i < 32; i++) begin
            send_word('0, 1'b0, 0);
            if (i == 0) first_fc = last_fc;
         end
      join
      chk("b2b_fire_span", 64'(last_fc - first_fc), 64'(31));
      drain();
      chk("b2b_word_cnt", 64'(word_cnt), 64'(32));
      chk_lat = 1'b0;

      // Held block: core must wait; early pt_last discards the rest of the block.
      send_block(rand_blk(), 0);
      @(negedge clk);
      chk("loaded_ks_ready", 64'(ks_ready), 64'(0));
      chk("loaded_pt_ready", 64'(pt_ready), 64'(1));
      @(posedge clk); #1;
      fork
         send_block(rand_blk(), 0);
         begin
            @(negedge clk);
            chk("offer_while_loaded_ks_ready", 64'(ks_ready), 64'(0));
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) send_word($urandom, i == 3, 0);
            for (int i = 0; i < 3; i++) send_word($urandom, i == 2, 0);
         end
      join
      drain();
      @(negedge clk);
      chk("early_last_ks_ready", 64'(ks_ready), 64'(1));
      @(posedge clk); #1;

      // Sink stall for 5 cycles mid-block.
      fork
         send_block(rand_blk(), 0);
         for (int i = 0; i < int'(NWORDS); i++) send_word($urandom, 1'b0, 0);
         begin
            repeat (8) @(posedge clk);
            #1 ct_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 ct_ready = 1'b1;
         end
      join
      drain();

      // Reset after 7 words of a block.
      fork
         send_block(rand_blk(), 0);
         for (int i = 0; i < 7; i++) send_word($urandom, 1'b0, 0);
      join
      do_reset();
      check_idle("midreset");
      fork
         send_block(rand_blk(), 0);
         for (int i = 0; i < 2; i++) send_word($urandom, i == 1, 0);
      join
      drain();

      // Random messages, random gaps and random sink backpressure.
      nblk = 0;
      foreach (lens[m]) begin
         lens[m] = int'($urandom_range(1, 40));
         nblk += (lens[m] + int'(NWORDS) - 1) / int'(NWORDS);
      end
      rnd_bp = 1'b1;
      fork
         for (int i = 0; i < nblk; i++) send_block(rand_blk(), int'($urandom_range(0, 20)));
         foreach (lens[m])
            for (int j = 0; j < lens[m]; j++)
               send_word($urandom, j == lens[m] - 1, int'($urandom_range(0, 2)));
      join
      rnd_bp = 1'b0;
      @(posedge clk);
      #2 ct_ready = 1'b1;
      drain();

      // Counter wrap (6-bit counter in this build).
      do_reset();
      fork
         for (int i = 0; i < 4; i++) send_block(rand_blk(), 0);
         for (int i = 0; i < 63; i++) send_word($urandom, 1'b0, 0);
      join
      drain();
      chk("wrap_cnt_63", 64'(word_cnt), 64'(63));
      fork
         send_block(rand_blk(), 0);
         send_word($urandom, 1'b0, 0);
      join
      drain();
      chk("wrap_cnt_0", 64'(word_cnt), 64'(0));
      send_word($urandom, 1'b0, 0);
      drain();
      chk("wrap_cnt_1", 64'(word_cnt), 64'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trivium_ks_xor.md
# trivium_ks_xor

Downstream stage of the Trivium encryption core: accepts 512-bit keystream blocks from the core's `OUT` bus over a valid/ready handshake, buffers one block, and XORs it word-by-word with an incoming plaintext stream to produce ciphertext. It sits between the keystream generator and the message datapath. It owns word indexing, block recycling, and message-boundary handling, so the core only has to produce whole blocks.

## Interface
- `BLK_W`, 512: keystream block width; must equal the core's output width.
- `WORD_W`, 32: plaintext/ciphertext word width; `BLK_W % WORD_W == 0`.
- `CNT_W`, 16: width of the ciphertext word counter.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ks_in` in BLK_W: keystream block from the core.
- `ks_valid` in 1: `ks_in` holds a fresh block.
- `ks_ready` out 1: block buffer can load this cycle.
- `pt_data` in WORD_W: plaintext word.
- `pt_valid` in 1: plaintext word present.
- `pt_last` in 1: final word of the message; qualified by `pt_valid`.
- `pt_ready` out 1: plaintext word accepted this cycle.
- `ct_data` out WORD_W: ciphertext word.
- `ct_valid` out 1: ciphertext word present.
- `ct_last` out 1: final ciphertext word of the message.
- `ct_ready` in 1: downstream accepts ciphertext.
- `word_cnt` out CNT_W: ciphertext words emitted since reset; wraps modulo 2^CNT_W.

## Operation
- Constant `NWORDS = BLK_W/WORD_W` (16). Word k of a block is `ks[WORD_W*k +: WORD_W]`; word 0 is consumed first.
- State is held in `blk_valid`, `idx` (log2 NWORDS bits), `blk` (BLK_W), and the output register (`ct_data`, `ct_valid`, `ct_last`).
- Two states, EMPTY (`blk_valid=0`) and LOADED (`blk_valid=1`).
  - EMPTY -> LOADED on `ks_valid && ks_ready`: `blk <= ks_in`, `idx <= 0`.
  - LOADED -> EMPTY when a plaintext word is accepted with `idx == NWORDS-1` or with `pt_last=1`, unless a new block loads in the same cycle (then remain LOADED with `idx <= 0`).
- Fire signals:
  - `out_free = !ct_valid || ct_ready`.
  - `pt_ready = blk_valid && out_free` (combinational).
  - `pt_fire = pt_valid && pt_ready`.
- On `pt_fire`:
  - `ct_data <= pt_data ^ blk[idx]`, `ct_valid <= 1`, `ct_last <= pt_last`, `idx <= idx+1`, `word_cnt <= word_cnt+1`.
  - `pt_last` discards the unused keystream words of the current block. The next message starts on a fresh block.
- With no `pt_fire` and `ct_ready=1`: `ct_valid <= 0`, `ct_last <= 0`.
- `ks_ready = !blk_valid || (pt_fire && (idx == NWORDS-1 || pt_last))`. This gives a same-cycle block swap with no bubble.
- Every keystream bit is used at most once; a block is never reused.
- Reset values: `blk_valid=0`, `idx=0`, `ct_valid=0`, `ct_last=0`, `ct_data=0`, `word_cnt=0`. `blk` is not reset. `ks_ready` is therefore 1 and `pt_ready` is 0 out of reset.
- Reset mid-message drops the buffered block and any pending ciphertext word. No partial output appears after reset deasserts.

## Timing
- Plaintext to ciphertext latency: 1 cycle (registered output).
- Throughput: 1 word/cycle sustained while `ct_ready=1` and the core supplies a block at least every NWORDS cycles.
- Block load to first `pt_ready`: 1 cycle.
- Backpressure: with `ct_valid=1 && ct_ready=0`, the output holds stable and `pt_ready=0`.
- `ct_data`, `ct_last`, and `ct_valid` must not change while `ct_valid && !ct_ready`.
- Simultaneous last-word consume and `ks_valid`: the new block loads, `idx` becomes 0, and the next word is accepted the following cycle.
- `ks_valid` while LOADED and not releasing: `ks_ready=0`, so the core holds its block.
- `word_cnt` wraps from 0xFFFF to 0x0000 with no flag.

## Structure
- A shared Trivium package holds `BLK_W`, `WORD_W`, and `NWORDS`. The core and this block import the same constants.
- No sub-module: the word mux and the XOR are inline.
- The top level instantiates the core with its `OUT` connected to `ks_in`.

## Test plan
- Word ordering: reset, then load `ks_in` with word k = 0x01010101*k, and stream 16 words `pt_data=0xFFFFFFFF` with `ct_ready=1`. Expect `ct_data` = ~(0x01010101*k) for k=0..15, one per cycle starting 1 cycle after the first `pt_fire`, then `ks_ready=1`.
- Back-to-back blocks: two blocks (all-0xA5, all-0x5A) with 32 plaintext words of 0. Expect 16×0xA5A5A5A5 then 16×0x5A5A5A5A with no bubble, and `word_cnt=32`.
- Early `pt_last`: assert `pt_last` on word 3 of a block. Expect `ct_last=1` on that word, the block discarded, and the next message's first word XORed with word 0 of the next block.
- Backpressure: hold `ct_ready=0` for 5 cycles mid-block. Expect `ct_data` stable, `pt_ready=0`, and no word lost or duplicated once released.
- Reset mid-block: reset after 7 words. Expect all outputs at reset values, `ks_ready=1`, `pt_ready=0`, and `word_cnt=0`.
- Counter wrap: preload `word_cnt` near 0xFFFF via 65535 words, or run a reduced-`CNT_W=4` build with 17 words. Expect wrap to 0 then 1.
